// File: rtl/vdp_sprite_pkg.sv
// Shared sprite definitions: effective magnified width, base source shift and stepper states.
package vdp_sprite_pkg;

    localparam int SPRITE_BASE_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } expand_state_t;

    // A magnification register of zero selects the full 256-pixel width.
    function automatic logic [8:0] effective_mgx(input logic [7:0] mgx);
        return (mgx == 8'd0) ? 9'd256 : {1'b0, mgx};
    endfunction

endpackage

// File: rtl/vdp_sprite_expand_calc.sv
// Combinational run calculator: accumulator s*M9 to screen start x and run length of sample s.
module vdp_sprite_expand_calc
    import vdp_sprite_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [8:0]  m9,
    input  logic [2:0]  sh,
    output logic [7:0]  x_start,
    output logic [4:0]  x_len
);

    logic [16:0] w_minus_1;
    logic [16:0] sum_start;
    logic [16:0] sum_next;

    // Adding W-1 before the shift turns the floor into the ceiling of s*M9/W.
    assign w_minus_1 = (17'd1 << sh) - 17'd1;
    assign sum_start = {1'b0, acc} + w_minus_1;
    assign sum_next  = sum_start + {8'd0, m9};

    assign x_start = 8'(sum_start >> sh);
    assign x_len   = 5'(9'(sum_next >> sh) - 9'(sum_start >> sh));

endmodule

// File: rtl/vdp_sprite_expand_stepper.sv
// Walks the source samples of one magnified sprite line and streams (sample, x, length) beats.
// Optional build macro VDP_SPRITE_EXPAND_SKIP_ZERO_EN suppresses zero-length beats.
module vdp_sprite_expand_stepper
    import vdp_sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] reg_mgx,
    input  logic [1:0] bit_shift,
    output logic       busy,
    output logic       o_valid,
    input  logic       o_ready,
    output logic [6:0] o_sample,
    output logic [7:0] o_x,
    output logic [4:0] o_len,
    output logic       o_last
);

    expand_state_t state;
    logic [8:0]  m9;
    logic [2:0]  sh;
    logic [6:0]  last_s;
    logic [6:0]  s;
    logic [15:0] acc;

    logic [15:0] acc_next;
    logic [15:0] calc_acc;
    logic [7:0]  calc_x;
    logic [4:0]  calc_len;

    // In OUT the calculator looks one sample ahead so the next beat loads on the handshake.
    assign acc_next = acc + {7'd0, m9};
    assign calc_acc = (state == OUT) ? acc_next : acc;

    vdp_sprite_expand_calc u_calc (
        .acc     (calc_acc),
        .m9      (m9),
        .sh      (sh),
        .x_start (calc_x),
        .x_len   (calc_len)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            m9       <= 9'd0;
            sh       <= 3'd0;
            last_s   <= 7'd0;
            s        <= 7'd0;
            acc      <= 16'd0;
            busy     <= 1'b0;
            o_valid  <= 1'b0;
            o_sample <= 7'd0;
            o_x      <= 8'd0;
            o_len    <= 5'd0;
            o_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m9     <= effective_mgx(reg_mgx);
                        sh     <= 3'(SPRITE_BASE_SHIFT) + {1'b0, bit_shift};
                        last_s <= 7'((8'd16 << bit_shift) - 8'd1);
                        s      <= 7'd0;
                        acc    <= 16'd0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    o_sample <= s;
                    o_x      <= calc_x;
                    o_len    <= calc_len;
                    o_last   <= (s == last_s);
`ifdef VDP_SPRITE_EXPAND_SKIP_ZERO_EN
                    if (calc_len == 5'd0) begin
                        s   <= s + 7'd1;
                        acc <= acc_next;
                    end else begin
                        o_valid <= 1'b1;
                        state   <= OUT;
                    end
`else
                    o_valid <= 1'b1;
                    state   <= OUT;
`endif
                end
                OUT: begin
                    if (o_ready) begin
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            s        <= s + 7'd1;
                            acc      <= acc_next;
                            o_sample <= s + 7'd1;
                            o_x      <= calc_x;
                            o_len    <= calc_len;
                            o_last   <= ((s + 7'd1) == last_s);
`ifdef VDP_SPRITE_EXPAND_SKIP_ZERO_EN
                            // An empty run drops back to CALC, which skips one sample per cycle.
                            if (calc_len == 5'd0) begin
                                o_valid <= 1'b0;
                                state   <= CALC;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
